// File: rtl/mips_pkg.sv
// Shared MIPS fetch/decode definitions: opcode constants, reset PC and fetch FSM states.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    EXEC = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_pc_next.sv
// Next-PC resolution: sequential pc+4 or beq-style taken target, all modulo 2^ADDR_W.
module fetch_pc_next #(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic [15:0]       imm,
  input  logic              branch,
  input  logic              alu_zero,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic [ADDR_W-1:0] next_pc
);

  logic [ADDR_W-1:0] br_offset;
  logic [ADDR_W-1:0] br_target;

  assign pc_plus4  = pc + ADDR_W'(4);
  // Word offset: sign-extended immediate scaled by 4.
  assign br_offset = {{(ADDR_W-18){imm[15]}}, imm, 2'b00};
  assign br_target = pc_plus4 + br_offset;
  assign next_pc   = (branch && alu_zero) ? br_target : pc_plus4;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, fetches over imem req/ack, holds instr for the decoder.
// Optional ack timeout with retry is enabled by defining FETCH_TIMEOUT_EN.
module instr_fetch_unit
  import mips_pkg::*;
#(
  parameter int                ADDR_W         = 32,
  parameter logic [ADDR_W-1:0] RESET_PC       = ADDR_W'(RESET_PC_DEFAULT),
  parameter int                TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  input  logic              branch,
  input  logic              alu_zero,
  input  logic              stall,
  output logic [31:0]       instr,
  output logic [5:0]        opcode,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic              fetch_err
);

  if (ADDR_W < 18 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 256) begin : g_bad_params
    $error("instr_fetch_unit: ADDR_W must be >= 18 and TIMEOUT_CYCLES in 1..256");
  end

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       instr_q, instr_d;
  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] next_pc;

`ifdef FETCH_TIMEOUT_EN
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       err_q, err_d;
`endif

  fetch_pc_next #(.ADDR_W(ADDR_W)) u_pc_next (
    .pc       (pc_q),
    .imm      (instr_q[15:0]),
    .branch   (branch),
    .alu_zero (alu_zero),
    .pc_plus4 (pc_plus4),
    .next_pc  (next_pc)
  );

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    valid_d  = valid_q;
    imem_req = 1'b0;
`ifdef FETCH_TIMEOUT_EN
    wait_cnt_d = wait_cnt_q;
    err_d      = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        state_d = REQ;
`ifdef FETCH_TIMEOUT_EN
        wait_cnt_d = 8'd0;
`endif
      end
      REQ: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          instr_d = imem_rdata;
          valid_d = 1'b1;
          state_d = EXEC;
        end
`ifdef FETCH_TIMEOUT_EN
        // Abandon the request for one IDLE cycle, then retry the same pc.
        else if (wait_cnt_q == WAIT_LAST) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
`endif
      end
      EXEC: begin
        if (!stall) begin
          valid_d = 1'b0;
          pc_d    = next_pc;
          state_d = REQ;
`ifdef FETCH_TIMEOUT_EN
          wait_cnt_d = 8'd0;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      instr_q <= 32'd0;
      valid_q <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      wait_cnt_q <= 8'd0;
      err_q      <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
`ifdef FETCH_TIMEOUT_EN
      wait_cnt_q <= wait_cnt_d;
      err_q      <= err_d;
`endif
    end
  end

  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign instr       = instr_q;
  assign opcode      = instr_q[31:26];
  assign instr_valid = valid_q;

`ifdef FETCH_TIMEOUT_EN
  assign fetch_err = err_q;
`else
  assign fetch_err = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized bench for instr_fetch_unit with a transaction-level PC model; two
// instances (reset PC 0 and 0xFFFF_FFFC) share stimulus.
module tb_instr_fetch_unit;
  import mips_pkg::*;

  localparam logic [31:0] RST_A = 32'h0000_0000;
  localparam logic [31:0] RST_B = 32'hFFFF_FFFC;

  logic        clk = 1'b0;
  logic        reset, imem_ack, branch, alu_zero, stall;
  logic [31:0] imem_rdata;

  logic        req_a, valid_a, err_a;
  logic [31:0] addr_a, instr_a, pc_a, pc4_a;
  logic [5:0]  op_a;
  logic        req_b, valid_b, err_b;
  logic [31:0] addr_b, instr_b, pc_b, pc4_b;
  logic [5:0]  op_b;

  int n_chk  = 0;
  int n_fail = 0;
  logic [31:0] exp_pc_a, exp_pc_b;

  always #5 clk = ~clk;

  instr_fetch_unit #(.ADDR_W(32), .RESET_PC(RST_A), .TIMEOUT_CYCLES(16)) u_dut_a (
    .clk(clk), .reset(reset), .imem_req(req_a), .imem_addr(addr_a), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .branch(branch), .alu_zero(alu_zero), .stall(stall),
    .instr(instr_a), .opcode(op_a), .instr_valid(valid_a), .pc(pc_a), .pc_plus4(pc4_a),
    .fetch_err(err_a)
  );

  instr_fetch_unit #(.ADDR_W(32), .RESET_PC(RST_B), .TIMEOUT_CYCLES(16)) u_dut_b (
    .clk(clk), .reset(reset), .imem_req(req_b), .imem_addr(addr_b), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .branch(branch), .alu_zero(alu_zero), .stall(stall),
    .instr(instr_b), .opcode(op_b), .instr_valid(valid_b), .pc(pc_b), .pc_plus4(pc4_b),
    .fetch_err(err_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Architectural rule: beq target = (pc + 4) + 4 * signed imm16, wrapping at 2^32.
  function automatic logic [31:0] model_next(input logic [31:0] cur, input logic [31:0] ins,
                                             input logic br, input logic z);
    logic signed [31:0] imm;
    imm = 32'($signed(ins[15:0]));
    if (br && z) return cur + 32'd4 + 32'(imm * 4);
    return cur + 32'd4;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full instruction: request, wait lat cycles, ack, stall nstall cycles, commit.
  task automatic fetch(input int lat, input logic [31:0] data, input int nstall,
                       input logic br, input logic z);
    check_eq("req_hi", 32'(req_a), 32'd1);
    check_eq("req_addr_a", addr_a, exp_pc_a);
    check_eq("req_addr_b", addr_b, exp_pc_b);
    check_eq("valid_in_req", 32'(valid_a), 32'd0);
    for (int i = 0; i < lat; i++) begin
      imem_ack   = 1'b0;
      stall      = 1'($urandom);
      imem_rdata = $urandom;
      tick();
      check_eq("wait_req", 32'(req_a), 32'd1);
      check_eq("wait_addr", addr_a, exp_pc_a);
      check_eq("wait_valid", 32'(valid_a), 32'd0);
      check_eq("wait_err", 32'(err_a), 32'd0);
    end
    imem_ack   = 1'b1;
    imem_rdata = data;
    stall      = 1'($urandom);
    tick();
    imem_ack = 1'b0;
    check_eq("exec_valid", 32'(valid_a), 32'd1);
    check_eq("exec_instr", instr_a, data);
    check_eq("exec_opcode", 32'(op_a), 32'(data[31:26]));
    check_eq("exec_req", 32'(req_a), 32'd0);
    check_eq("exec_pc_a", pc_a, exp_pc_a);
    check_eq("exec_pc4_a", pc4_a, exp_pc_a + 32'd4);
    check_eq("exec_pc_b", pc_b, exp_pc_b);
    check_eq("exec_valid_b", 32'(valid_b), 32'd1);
    for (int i = 0; i < nstall; i++) begin
      stall      = 1'b1;
      imem_ack   = 1'($urandom);
      imem_rdata = $urandom;
      branch     = 1'($urandom);
      alu_zero   = 1'($urandom);
      tick();
      check_eq("stall_valid", 32'(valid_a), 32'd1);
      check_eq("stall_instr", instr_a, data);
      check_eq("stall_pc", pc_a, exp_pc_a);
      check_eq("stall_req", 32'(req_a), 32'd0);
    end
    stall    = 1'b0;
    imem_ack = 1'b0;
    branch   = br;
    alu_zero = z;
    tick();
    branch   = 1'b0;
    alu_zero = 1'b0;
    exp_pc_a = model_next(exp_pc_a, data, br, z);
    exp_pc_b = model_next(exp_pc_b, data, br, z);
    check_eq("commit_valid", 32'(valid_a), 32'd0);
    check_eq("commit_pc", pc_a, exp_pc_a);
  endtask

  initial begin
    reset = 1'b1; imem_ack = 1'b0; imem_rdata = 32'd0;
    branch = 1'b0; alu_zero = 1'b0; stall = 1'b0;
    exp_pc_a = RST_A;
    exp_pc_b = RST_B;

    repeat (3) tick();
    check_eq("rst_req", 32'(req_a), 32'd0);
    check_eq("rst_valid", 32'(valid_a), 32'd0);
    check_eq("rst_instr", instr_a, 32'd0);
    check_eq("rst_pc_a", pc_a, RST_A);
    check_eq("rst_pc_b", pc_b, RST_B);
    check_eq("rst_err", 32'(err_a), 32'd0);

    reset = 1'b0;
    check_eq("idle_req", 32'(req_a), 32'd0);
    tick();

    fetch(0, 32'h8C01_0004, 0, 1'b0, 1'b0);
    check_eq("wrap_addr_b", addr_b, 32'h0000_0000);
    fetch(3, 32'h0000_0020, 0, 1'b0, 1'b0);
    check_eq("seq_addr", addr_a, 32'h0000_0008);
    fetch(3, 32'h1000_FFFE, 0, 1'b1, 1'b1);
    check_eq("br_taken_addr", addr_a, 32'h0000_0004);
    fetch(1, 32'h2000_0001, 0, 1'b0, 1'b0);
    fetch(1, 32'h1000_FFFE, 3, 1'b1, 1'b0);
    check_eq("br_not_taken_addr", addr_a, 32'h0000_000C);

    for (int n = 0; n < 40; n++) begin
      fetch(int'($urandom_range(0, 5)), $urandom, int'($urandom_range(0, 3)),
            1'($urandom), 1'($urandom));
    end

    // Reset in the middle of a request, with a coincident ack.
    imem_ack = 1'b0;
    tick();
    reset      = 1'b1;
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_ack = 1'b0;
    check_eq("midrst_req", 32'(req_a), 32'd0);
    check_eq("midrst_valid", 32'(valid_a), 32'd0);
    check_eq("midrst_instr", instr_a, 32'd0);
    check_eq("midrst_pc", pc_a, RST_A);
    reset    = 1'b0;
    exp_pc_a = RST_A;
    exp_pc_b = RST_B;
    check_eq("midrst_idle_req", 32'(req_a), 32'd0);
    tick();
    fetch(0, 32'hAC22_0010, 1, 1'b0, 1'b0);

`ifdef FETCH_TIMEOUT_EN
    for (int i = 0; i < 15; i++) begin
      imem_ack = 1'b0;
      tick();
      check_eq("to_wait_err", 32'(err_a), 32'd0);
      check_eq("to_wait_req", 32'(req_a), 32'd1);
    end
    tick();
    check_eq("to_err_pulse", 32'(err_a), 32'd1);
    check_eq("to_req_drop", 32'(req_a), 32'd0);
    check_eq("to_pc_hold", pc_a, exp_pc_a);
    tick();
    check_eq("to_err_clear", 32'(err_a), 32'd0);
    check_eq("to_reissue_addr", addr_a, exp_pc_a);
`else
    for (int i = 0; i < 20; i++) begin
      imem_ack = 1'b0;
      tick();
      check_eq("noto_err", 32'(err_a), 32'd0);
      check_eq("noto_req", 32'(req_a), 32'd1);
    end
`endif
    fetch(2, 32'h0000_0000, 0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
